// File: rtl/uart_tx_sequencer.sv
// UART 8N1 transmit sequencer: byte handshake in, load/enable pulses out to a 10-bit shifter.
// Optional UART_TX_STOP2_EN: stop phase spans two bit periods (done one bit later).
module uart_tx_sequencer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] key,
    output logic       load,
    output logic       enable,
    output logic       busy,
    output logic       done
);

    localparam int                CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        LAST_DATA = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           r_state,    w_state_nxt;
    logic [CNT_W-1:0] r_baud_cnt, w_baud_cnt_nxt;
    logic [3:0]       r_bit_cnt,  w_bit_cnt_nxt;
    logic [7:0]       r_key,      w_key_nxt;
    logic             r_tx_ready, w_tx_ready_nxt;
    logic             r_load,     w_load_nxt;
    logic             r_enable,   w_enable_nxt;
    logic             r_busy,     w_busy_nxt;
    logic             r_done,     w_done_nxt;
    logic             w_bit_tick;
    logic             w_stop_last;

`ifdef UART_TX_STOP2_EN
    // Marks that the first of the two stop-bit periods has elapsed.
    logic r_stop_half, w_stop_half_nxt;
    assign w_stop_last = r_stop_half;
`else
    assign w_stop_last = 1'b1;
`endif

    assign w_bit_tick = (r_baud_cnt == BAUD_LAST);

    assign tx_ready = r_tx_ready;
    assign key      = r_key;
    assign load     = r_load;
    assign enable   = r_enable;
    assign busy     = r_busy;
    assign done     = r_done;

    always_comb begin
        w_state_nxt    = r_state;
        w_baud_cnt_nxt = r_baud_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_key_nxt      = r_key;
        w_tx_ready_nxt = r_tx_ready;
        w_busy_nxt     = r_busy;
        w_load_nxt     = 1'b0;
        w_enable_nxt   = 1'b0;
        w_done_nxt     = 1'b0;
`ifdef UART_TX_STOP2_EN
        w_stop_half_nxt = r_stop_half;
`endif

        if (r_state != S_IDLE) begin
            w_baud_cnt_nxt = w_bit_tick ? '0 : r_baud_cnt + 1'b1;
        end

        unique case (r_state)
            S_IDLE: begin
                if (tx_valid && r_tx_ready) begin
                    w_key_nxt      = tx_data;
                    w_load_nxt     = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_tx_ready_nxt = 1'b0;
                    w_baud_cnt_nxt = '0;
                    w_bit_cnt_nxt  = '0;
                    w_state_nxt    = S_START;
`ifdef UART_TX_STOP2_EN
                    w_stop_half_nxt = 1'b0;
`endif
                end
            end
            S_START: begin
                if (w_bit_tick) begin
                    w_enable_nxt  = 1'b1;
                    w_bit_cnt_nxt = 4'd1;
                    w_state_nxt   = S_DATA;
                end
            end
            S_DATA: begin
                // Pulses 2..9 shift out data[0..7]; the ninth brings the stop bit to the line.
                if (w_bit_tick) begin
                    w_enable_nxt  = 1'b1;
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == LAST_DATA) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_tick) begin
                    if (w_stop_last) begin
                        w_done_nxt     = 1'b1;
                        w_busy_nxt     = 1'b0;
                        w_tx_ready_nxt = 1'b1;
                        w_state_nxt    = S_IDLE;
                    end
`ifdef UART_TX_STOP2_EN
                    else begin
                        w_stop_half_nxt = 1'b1;
                    end
`endif
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_key      <= '0;
            r_tx_ready <= 1'b1;
            r_load     <= 1'b0;
            r_enable   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef UART_TX_STOP2_EN
            r_stop_half <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_key      <= w_key_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_load     <= w_load_nxt;
            r_enable   <= w_enable_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
`ifdef UART_TX_STOP2_EN
            r_stop_half <= w_stop_half_nxt;
`endif
        end
    end

    a_no_load_with_enable: assert property (@(posedge clk) disable iff (reset) !(r_load && r_enable));

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Randomized bench for uart_tx_sequencer; reference model derives every output from the
// cycle offset since the frame's load cycle.
module tb_uart_tx_sequencer;

    localparam int C = 4;
`ifdef UART_TX_STOP2_EN
    localparam int STOPS = 11;
`else
    localparam int STOPS = 10;
`endif
    localparam int FRAME = STOPS * C;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = '0;
    logic       tx_ready, load, enable, busy, done;
    logic [7:0] key;

    uart_tx_sequencer #(.CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .key      (key),
        .load     (load),
        .enable   (enable),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int         n_cmp   = 0;
    int         n_mis   = 0;
    int         cyc     = 0;
    int         frame_L = -1;
    int         en_seen = 0;
    logic [7:0] m_key   = 8'h00;
    bit         m_acc   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Frame occupies cycles L .. L+FRAME-1; done falls on L+FRAME.
    function automatic bit m_busy();
        int dd;
        dd = cyc - frame_L;
        return (frame_L >= 0) && (dd >= 0) && (dd < FRAME);
    endfunction

    task automatic compare_now();
        int d;
        bit act;
        d   = cyc - frame_L;
        act = m_busy();
        chk("tx_ready", 32'(tx_ready), 32'(!act));
        chk("busy",     32'(busy),     32'(act));
        chk("load",     32'(load),     32'(act && d == 0));
        chk("enable",   32'(enable),   32'(act && d >= C && d <= 9 * C && (d % C) == 0));
        chk("done",     32'(done),     32'(frame_L >= 0 && d == FRAME));
        chk("key",      32'(key),      32'(m_key));
        if (load === 1'b1) en_seen = 0;
        if (enable === 1'b1) en_seen++;
        if (done === 1'b1) chk("en_per_frame", 32'(en_seen), 32'd9);
    endtask

    task automatic cycle(input logic v, input logic [7:0] d);
        @(negedge clk);
        cyc++;
        compare_now();
        tx_valid = v;
        tx_data  = d;
        m_acc    = 1'b0;
        if (!reset && v && !m_busy()) begin
            frame_L = cyc + 1;
            m_key   = d;
            m_acc   = 1'b1;
        end
    endtask

    task automatic reset_pulse(input int hold);
        @(negedge clk);
        cyc++;
        compare_now();
        reset    = 1'b1;
        tx_valid = 1'b0;
        #1;
        chk("async_tx_ready", 32'(tx_ready), 32'd1);
        chk("async_busy",     32'(busy),     32'd0);
        chk("async_load",     32'(load),     32'd0);
        chk("async_enable",   32'(enable),   32'd0);
        chk("async_done",     32'(done),     32'd0);
        chk("async_key",      32'(key),      32'd0);
        frame_L = -1;
        m_key   = 8'h00;
        en_seen = 0;
        repeat (hold) begin
            @(negedge clk);
            cyc++;
            compare_now();
        end
        reset = 1'b0;
    endtask

    initial begin
        repeat (3) cycle(1'b0, 8'h00);
        reset = 1'b0;
        repeat (20) cycle(1'b0, 8'($urandom));

        cycle(1'b1, 8'hA5);
        repeat (FRAME + 4) cycle(1'b0, 8'($urandom));

        for (int i = 0; i < 20 && !m_acc; i++) cycle(1'b1, 8'h3C);
        cycle(1'b1, 8'hC3);
        for (int i = 0; i < 200 && !m_acc; i++) cycle(1'b1, 8'hC3);
        repeat (FRAME + 4) cycle(1'b0, 8'($urandom));

        cycle(1'b1, 8'h5A);
        repeat (10) cycle(1'b0, 8'($urandom));
        repeat (2 * C + 1) cycle(1'b1, 8'hFF);
        repeat (FRAME) cycle(1'b0, 8'($urandom));

        cycle(1'b1, 8'h81);
        while (cyc < frame_L + 16) cycle(1'b0, 8'($urandom));
        reset_pulse(2);
        cycle(1'b1, 8'h42);
        repeat (FRAME + 4) cycle(1'b0, 8'($urandom));

        cycle(1'b1, 8'h00);
        repeat (FRAME + 4) cycle(1'b0, 8'($urandom));

        repeat (3000) begin
            if ($urandom_range(0, 599) == 0) reset_pulse(int'($urandom_range(1, 3)));
            else cycle($urandom_range(0, 2) == 0, 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
